// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU and load results into an in-order FIFO that feeds a registered register-file write port.
// Optional zero-queue bypass into the output stage is enabled with `define WRITEBACK_BYPASS_EN.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [4:0]                alu_rd,
  input  logic [63:0]               alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [4:0]                mem_rd,
  input  logic [63:0]               mem_data,
  output logic                      wb_en,
  output logic [4:0]                wb_addr,
  output logic [63:0]               wb_data,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [68:0]   entries [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] free_slots;
  logic          mem_keep;
  logic          alu_keep;
  logic          first_v;
  logic          second_v;
  logic [68:0]   first_e;
  logic [68:0]   second_e;
  logic          push0_v;
  logic          push1_v;
  logic [68:0]   push0_e;
  logic [68:0]   push1_e;
  logic          pop;
  logic          bypass;
  logic [68:0]   head;

  // Readies use the occupancy at cycle start; the load wins the last free slot.
  assign free_slots = FULL - fifo_count;
  assign mem_ready  = !reset && (fifo_count < FULL);
  assign alu_ready  = !reset && ((free_slots >= CW'(2)) ||
                                 ((free_slots == CW'(1)) && !mem_valid));

  assign mem_keep = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign alu_keep = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign pop      = (fifo_count != '0);
  assign head     = entries[rd_ptr];
  assign busy     = (fifo_count != '0) || wb_en;

  always_comb begin
    first_v  = 1'b0;
    second_v = 1'b0;
    first_e  = '0;
    second_e = '0;
    bypass   = 1'b0;
    if (mem_keep) begin
      first_v  = 1'b1;
      first_e  = {mem_rd, mem_data};
      second_v = alu_keep;
      second_e = {alu_rd, alu_data};
    end else if (alu_keep) begin
      first_v = 1'b1;
      first_e = {alu_rd, alu_data};
    end
`ifdef WRITEBACK_BYPASS_EN
    bypass = first_v && (fifo_count == '0);
`else
    bypass = 1'b0;
`endif
    // A bypassed entry goes straight to the output stage, so only the other one is queued.
    push0_v = bypass ? second_v : first_v;
    push0_e = bypass ? second_e : first_e;
    push1_v = bypass ? 1'b0 : second_v;
    push1_e = second_e;
  end

  always_ff @(posedge clk) begin
    if (push0_v)
      entries[wr_ptr] <= push0_e;
    if (push1_v)
      entries[wr_ptr + AW'(1)] <= push1_e;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      fifo_count <= fifo_count + CW'(push0_v) + CW'(push1_v) - CW'(pop);
      wr_ptr     <= wr_ptr + AW'(push0_v) + AW'(push1_v);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        wb_en   <= 1'b1;
        wb_addr <= head[68:64];
        wb_data <= head[63:0];
      end else if (bypass) begin
        wb_en   <= 1'b1;
        wb_addr <= first_e[68:64];
        wb_data <= first_e[63:0];
      end else begin
        wb_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours `define WRITEBACK_BYPASS_EN.
module tb_writeback_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [2:0]  fifo_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ent_t mq[$];
  ent_t incoming[$];
  ent_t accepted[$];
  ent_t emitted[$];
  logic        m_en = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [63:0] m_data = '0;
  int          max_count = 0;

  always #5 clk = ~clk;

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .fifo_count(fifo_count), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                               input logic av, input logic [4:0] ard, input logic [63:0] ad);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
  endtask

  // Reference model: checks state reached at the previous edge, then predicts the next edge.
  int   free_n;
  logic exp_mr;
  logic exp_ar;
  ent_t e;

  always @(negedge clk) begin
    free_n = DEPTH - mq.size();
    exp_mr = !reset && (mq.size() < DEPTH);
    exp_ar = !reset && ((free_n >= 2) || ((free_n == 1) && !mem_valid));
    checkOutput("wb_en", 64'(wb_en), 64'(m_en));
    checkOutput("wb_addr", 64'(wb_addr), 64'(m_addr));
    checkOutput("wb_data", wb_data, m_data);
    checkOutput("fifo_count", 64'(fifo_count), 64'(mq.size()));
    checkOutput("busy", 64'(busy), 64'((mq.size() != 0) || m_en));
    checkOutput("mem_ready", 64'(mem_ready), 64'(exp_mr));
    checkOutput("alu_ready", 64'(alu_ready), 64'(exp_ar));
    if (wb_en === 1'b1) emitted.push_back('{rd: wb_addr, data: wb_data});
    if (int'(fifo_count) > max_count) max_count = int'(fifo_count);

    if (reset) begin
      mq.delete();
      m_en = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      incoming.delete();
      if (mem_valid && exp_mr && mem_rd != 5'd0) incoming.push_back('{rd: mem_rd, data: mem_data});
      if (alu_valid && exp_ar && alu_rd != 5'd0) incoming.push_back('{rd: alu_rd, data: alu_data});
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_en = 1'b1; m_addr = e.rd; m_data = e.data;
      end
`ifdef WRITEBACK_BYPASS_EN
      else if (incoming.size() > 0) begin
        e = incoming.pop_front();
        m_en = 1'b1; m_addr = e.rd; m_data = e.data;
      end
`endif
      else begin
        m_en = 1'b0;
      end
      foreach (incoming[i]) mq.push_back(incoming[i]);
    end
  end

  int mi;
  int ai;
  int cyc;
  int n_before;

  initial begin
    reset = 1'b1;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_wb_en", 64'(wb_en), 64'h0);
    checkOutput("reset_fifo_count", 64'(fifo_count), 64'h0);
    checkOutput("reset_wb_addr", 64'(wb_addr), 64'h0);
    idle();

    // Single ALU write, rd=3 data=0xAA
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'hAA);
`ifdef WRITEBACK_BYPASS_EN
    checkOutput("single_en", 64'(wb_en), 64'h1);
    checkOutput("single_addr", 64'(wb_addr), 64'h3);
    checkOutput("single_data", wb_data, 64'hAA);
    idle();
`else
    checkOutput("single_not_yet", 64'(wb_en), 64'h0);
    checkOutput("single_count", 64'(fifo_count), 64'h1);
    idle();
    checkOutput("single_en", 64'(wb_en), 64'h1);
    checkOutput("single_addr", 64'(wb_addr), 64'h3);
    checkOutput("single_data", wb_data, 64'hAA);
    idle();
`endif
    checkOutput("single_done", 64'(wb_en), 64'h0);
    checkOutput("single_hold", wb_data, 64'hAA);
    idle();

    // Same-cycle collision on rd=5: load first, ALU last
    applyStimulus(1'b1, 5'd5, 64'h11, 1'b1, 5'd5, 64'h22);
`ifndef WRITEBACK_BYPASS_EN
    checkOutput("collide_count", 64'(fifo_count), 64'h2);
    idle();
`endif
    checkOutput("collide_first", wb_data, 64'h11);
    checkOutput("collide_addr", 64'(wb_addr), 64'h5);
    idle();
    checkOutput("collide_second_en", 64'(wb_en), 64'h1);
    checkOutput("collide_second", wb_data, 64'h22);
    idle();
    checkOutput("collide_done", 64'(wb_en), 64'h0);

    // rd=0 is consumed without a write
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
    #7;
    checkOutput("rd0_ready", 64'(alu_ready), 64'h1);
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    checkOutput("rd0_count", 64'(fifo_count), 64'h0);
    checkOutput("rd0_en", 64'(wb_en), 64'h0);
    idle();
    checkOutput("rd0_en_later", 64'(wb_en), 64'h0);
    idle();

    // Both producers hold valid until their 8 items each are taken
    accepted.delete();
    emitted.delete();
    max_count = 0;
    mi = 0; ai = 0; cyc = 0;
    while ((mi < 8 || ai < 8) && cyc < 200) begin
      mem_valid = (mi < 8); mem_rd = 5'(1 + mi);  mem_data = 64'h1000 + 64'(mi);
      alu_valid = (ai < 8); alu_rd = 5'(17 + ai); alu_data = 64'h2000 + 64'(ai);
      #8;
      if (mem_valid && mem_ready) begin
        accepted.push_back('{rd: mem_rd, data: mem_data});
        mi++;
      end
      if (alu_valid && alu_ready) begin
        accepted.push_back('{rd: alu_rd, data: alu_data});
        ai++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("stream_finished", 64'(cyc < 200), 64'h1);
    repeat (10) idle();
    checkOutput("stream_writes", 64'(emitted.size()), 64'd16);
    checkOutput("stream_max_count", 64'(max_count <= DEPTH), 64'h1);
    if (emitted.size() > 0)
      checkOutput("stream_first", emitted[0].data, 64'h1000);
    for (int i = 0; i < emitted.size() && i < accepted.size(); i++) begin
      checkOutput("stream_order_rd", 64'(emitted[i].rd), 64'(accepted[i].rd));
      checkOutput("stream_order_data", emitted[i].data, accepted[i].data);
    end

    // Fill to three entries, then reset mid-stream
    applyStimulus(1'b1, 5'd7, 64'h71, 1'b1, 5'd8, 64'h81);
    applyStimulus(1'b1, 5'd9, 64'h91, 1'b1, 5'd10, 64'hA1);
`ifdef WRITEBACK_BYPASS_EN
    applyStimulus(1'b1, 5'd13, 64'hD1, 1'b1, 5'd14, 64'hE1);
`endif
    idle_inputs_only();
    checkOutput("fill_count", 64'(fifo_count), 64'h3);
    reset = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 64'hB1;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'hC1;
    #2;
    checkOutput("reset_mem_ready", 64'(mem_ready), 64'h0);
    checkOutput("reset_alu_ready", 64'(alu_ready), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_valid = 1'b0; alu_valid = 1'b0;
    checkOutput("midreset_count", 64'(fifo_count), 64'h0);
    checkOutput("midreset_en", 64'(wb_en), 64'h0);
    checkOutput("midreset_busy", 64'(busy), 64'h0);
    n_before = emitted.size();
    repeat (5) idle();
    checkOutput("post_reset_writes", 64'(emitted.size() - n_before), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic idle_inputs_only();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

endmodule
